// File: rtl/huc_mem_ctrl_pkg.sv
// Shared types for the HuCard memory back-end: mapper request channel,
// controller state encoding and the latched request slot.
package huc_mem_ctrl_pkg;

  localparam int MEM_AW = 22;
  localparam int CH_AW  = 20;

  typedef struct packed {
    logic             ce;
    logic             oe;
    logic             we;
    logic [CH_AW-1:0] addr;
    logic [7:0]       dati;
  } MemCtrl;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSU,
    WR,
    WH
  } MemSt_t;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [7:0]        dat;
    logic              wr;
    logic              is_ram;
  } MemReq_t;

endpackage

// File: rtl/huc_mem_ctrl_req_det.sv
// Per-channel trigger detector: fires once per rising strobe or address change
// and latches the request so the mapper is free to move on.
module huc_req_det
  import huc_mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [CH_AW-1:0] addr,
  input  logic [7:0]       dat,
  input  logic             wr,
  output logic             trig,
  output logic [CH_AW-1:0] addr_q,
  output logic [7:0]       dat_q,
  output logic             wr_q
);

  logic             prev_req;
  logic [CH_AW-1:0] prev_addr;
  logic             hit;

  assign hit = req & (~prev_req | (addr != prev_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_req  <= 1'b0;
      prev_addr <= '0;
      trig      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      wr_q      <= 1'b0;
    end else begin
      prev_req  <= req;
      prev_addr <= addr;
      trig      <= hit;
      if (hit) begin
        addr_q <= addr;
        dat_q  <= dat;
        wr_q   <= wr;
      end
    end
  end

endmodule

// File: rtl/huc_mem_ctrl.sv
// Serialises the mapper's ROM and RAM channels onto one 8-bit async memory
// bus with programmable read/write strobe lengths and a one-deep pending slot.
module huc_mem_ctrl
  import huc_mem_ctrl_pkg::*;
#(
  parameter int                RD_CYC   = 4,
  parameter int                WR_CYC   = 4,
  parameter logic [MEM_AW-1:0] RAM_BASE = 22'h200000
) (
  input  logic              clk,
  input  logic              rst,
  input  MemCtrl            rom,
  input  MemCtrl            ram,
  output logic [7:0]        rom_dato,
  output logic [7:0]        ram_dato,
  output logic              busy,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_dato,
  input  logic [7:0]        mem_dati,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we
);

  localparam int CNT_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  logic             rom_trig, ram_trig;
  logic [CH_AW-1:0] rom_addr_q, ram_addr_q;
  logic [7:0]       rom_dat_q, ram_dat_q;
  logic             rom_wr_q, ram_wr_q;

  huc_req_det u_rom_det (
    .clk    (clk),
    .rst    (rst),
    .req    (rom.ce & (rom.oe | rom.we)),
    .addr   (rom.addr),
    .dat    (rom.dati),
    .wr     (1'b0),
    .trig   (rom_trig),
    .addr_q (rom_addr_q),
    .dat_q  (rom_dat_q),
    .wr_q   (rom_wr_q)
  );

  huc_req_det u_ram_det (
    .clk    (clk),
    .rst    (rst),
    .req    (ram.ce & (ram.oe | ram.we)),
    .addr   (ram.addr),
    .dat    (ram.dati),
    .wr     (ram.we),
    .trig   (ram_trig),
    .addr_q (ram_addr_q),
    .dat_q  (ram_dat_q),
    .wr_q   (ram_wr_q)
  );

  MemSt_t          state;
  logic [CW-1:0]   cnt;
  logic            cur_is_ram;
  MemReq_t         pend_slot;
  logic            pend_valid;
  MemReq_t         rom_slot, ram_slot, go_slot, pend_nxt;
  logic            go, pend_vld_nxt, rom_left, ram_left;

  always_comb begin
    rom_slot.addr   = {{(MEM_AW-CH_AW){1'b0}}, rom_addr_q};
    rom_slot.dat    = rom_dat_q;
    rom_slot.wr     = rom_wr_q;
    rom_slot.is_ram = 1'b0;
    ram_slot.addr   = RAM_BASE + {{(MEM_AW-CH_AW){1'b0}}, ram_addr_q};
    ram_slot.dat    = ram_dat_q;
    ram_slot.wr     = ram_wr_q;
    ram_slot.is_ram = 1'b1;
  end

  // Pending is served first from IDLE; any trigger not started lands in the
  // pending slot, RAM taking precedence when both channels fire together.
  always_comb begin
    go           = 1'b0;
    go_slot      = pend_slot;
    pend_nxt     = pend_slot;
    pend_vld_nxt = pend_valid;
    rom_left     = rom_trig;
    ram_left     = ram_trig;
    if (state == IDLE) begin
      if (pend_valid) begin
        go           = 1'b1;
        go_slot      = pend_slot;
        pend_vld_nxt = 1'b0;
      end else if (ram_trig) begin
        go       = 1'b1;
        go_slot  = ram_slot;
        ram_left = 1'b0;
      end else if (rom_trig) begin
        go       = 1'b1;
        go_slot  = rom_slot;
        rom_left = 1'b0;
      end
    end
    if (ram_left) begin
      pend_nxt     = ram_slot;
      pend_vld_nxt = 1'b1;
    end else if (rom_left) begin
      pend_nxt     = rom_slot;
      pend_vld_nxt = 1'b1;
    end
  end

  assign busy = (state != IDLE) | pend_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_is_ram <= 1'b0;
      pend_slot  <= '0;
      pend_valid <= 1'b0;
      rom_dato   <= '0;
      ram_dato   <= '0;
      mem_addr   <= '0;
      mem_dato   <= '0;
      mem_ce     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      pend_slot  <= pend_nxt;
      pend_valid <= pend_vld_nxt;
      case (state)
        IDLE: begin
          if (go) begin
            cur_is_ram <= go_slot.is_ram;
            mem_addr   <= go_slot.addr;
            mem_ce     <= 1'b1;
            if (go_slot.wr) begin
              state    <= WSU;
              mem_dato <= go_slot.dat;
            end else begin
              state  <= RD;
              mem_oe <= 1'b1;
              cnt    <= CW'(RD_CYC - 1);
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            mem_ce <= 1'b0;
            mem_oe <= 1'b0;
            if (cur_is_ram) ram_dato <= mem_dati;
            else            rom_dato <= mem_dati;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WSU: begin
          state  <= WR;
          mem_we <= 1'b1;
          cnt    <= CW'(WR_CYC - 1);
        end
        WR: begin
          if (cnt == '0) begin
            state  <= WH;
            mem_we <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WH: begin
          state  <= IDLE;
          mem_ce <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huc_mem_ctrl.sv
// Scoreboard bench for huc_mem_ctrl: stimulus pushes expected bus accesses,
// a bus monitor pops and checks each completed access.
`timescale 1ns/1ps
module tb_huc_mem_ctrl;
  import huc_mem_ctrl_pkg::*;

  localparam int          RD    = 4;
  localparam int          WRC   = 4;
  localparam logic [21:0] RBASE = 22'h200000;

  logic        clk = 1'b0;
  logic        rst;
  MemCtrl      rom, ram;
  logic [7:0]  rom_dato, ram_dato, mem_dato, mem_dati;
  logic        busy, mem_ce, mem_oe, mem_we;
  logic [21:0] mem_addr;

  logic        force_en  = 1'b0;
  logic [7:0]  force_val = 8'h00;
  int          checks = 0, errors = 0, acc_count = 0;
  logic [7:0]  model_rom = 8'h00, model_ram = 8'h00;

  typedef struct {
    logic        wr;
    logic        is_ram;
    logic [21:0] addr;
    logic [7:0]  dat;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  huc_mem_ctrl #(.RD_CYC(RD), .WR_CYC(WRC), .RAM_BASE(RBASE)) dut (
    .clk(clk), .rst(rst), .rom(rom), .ram(ram),
    .rom_dato(rom_dato), .ram_dato(ram_dato), .busy(busy),
    .mem_addr(mem_addr), .mem_dato(mem_dato), .mem_dati(mem_dati),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we)
  );

  // External memory content is a fixed function of the address.
  function automatic logic [7:0] pattern(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_data(input logic [21:0] a);
    return force_en ? force_val : pattern(a);
  endfunction

  assign mem_dati = force_en ? force_val : pattern(mem_addr);

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor
  logic        active = 1'b0;
  logic [21:0] a_addr;
  logic [7:0]  a_dat;
  int          n_ce, n_oe, n_we;
  logic        first_we, last_we;

  task automatic finish_access();
    exp_t e;
    acc_count++;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_unexpected: got access at 0x%0h, want none", a_addr);
    end else begin
      e = sbq.pop_front();
      check_output("acc_dir", 32'(n_we != 0), 32'(e.wr));
      check_output("acc_addr", 32'(a_addr), 32'(e.addr));
      if (e.wr) begin
        check_output("wr_data", 32'(a_dat), 32'(e.dat));
        check_output("wr_we_cycles", 32'(n_we), 32'(WRC));
        check_output("wr_occupancy", 32'(n_ce), 32'(WRC + 2));
        check_output("wr_setup_we", 32'(first_we), 32'd0);
        check_output("wr_hold_we", 32'(last_we), 32'd0);
        check_output("wr_no_oe", 32'(n_oe), 32'd0);
      end else begin
        check_output("rd_oe_cycles", 32'(n_oe), 32'(RD));
        check_output("rd_ce_cycles", 32'(n_ce), 32'(RD));
        check_output("rd_no_we", 32'(n_we), 32'd0);
        if (e.is_ram) model_ram = e.dat;
        else          model_rom = e.dat;
      end
      check_output("rom_dato", 32'(rom_dato), 32'(model_rom));
      check_output("ram_dato", 32'(ram_dato), 32'(model_ram));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else if (!active && mem_ce) begin
      active   = 1'b1;
      a_addr   = mem_addr;
      a_dat    = mem_dato;
      n_ce     = 1;
      n_oe     = int'(mem_oe);
      n_we     = int'(mem_we);
      first_we = mem_we;
      last_we  = mem_we;
    end else if (active && mem_ce) begin
      n_ce    = n_ce + 1;
      n_oe    = n_oe + int'(mem_oe);
      n_we    = n_we + int'(mem_we);
      last_we = mem_we;
    end else if (active && !mem_ce) begin
      active = 1'b0;
      finish_access();
    end
  end

  task automatic push_exp(input logic wr, input logic is_ram, input logic [21:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = wr; e.is_ram = is_ram; e.addr = a; e.dat = d;
    sbq.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || active || sbq.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (busy || active || sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got %0d accesses outstanding, want 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input bit use_rom, input logic [19:0] ra, input bit use_ram,
                                input logic [14:0] wa, input bit wr, input logic [7:0] wd,
                                input int hold);
    logic [21:0] ea;
    @(negedge clk);
    if (use_ram) begin
      ram.ce = 1'b1; ram.oe = ~wr; ram.we = wr; ram.addr = {5'b0, wa}; ram.dati = wd;
      ea = RBASE + {7'b0, wa};
      push_exp(wr, 1'b1, ea, wr ? wd : rd_data(ea));
    end
    if (use_rom) begin
      rom.ce = 1'b1; rom.oe = 1'b1; rom.we = 1'b0; rom.addr = ra; rom.dati = 8'($urandom);
      ea = {2'b00, ra};
      push_exp(1'b0, 1'b0, ea, rd_data(ea));
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rom = '0;
    ram = '0;
  endtask

  initial begin
    int start;
    int n;
    logic seen;
    rst = 1'b1;
    rom = '0;
    ram = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_strobes", {29'd0, mem_ce, mem_oe, mem_we}, 32'd0);
    check_output("rst_addr", 32'(mem_addr), 32'd0);
    check_output("rst_dato", 32'(mem_dato), 32'd0);
    check_output("rst_rom_dato", 32'(rom_dato), 32'd0);
    check_output("rst_ram_dato", 32'(ram_dato), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed ROM read timing");
    force_en = 1'b1; force_val = 8'hA5;
    @(negedge clk);
    rom.ce = 1'b1; rom.oe = 1'b1; rom.addr = 20'h01234;
    push_exp(1'b0, 1'b0, 22'h001234, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    rom = '0;
    repeat (RD) @(posedge clk);
    #1;
    check_output("t1_rom_dato_early", 32'(rom_dato), 32'd0);
    check_output("t1_oe_late", 32'(mem_oe), 32'd1);
    check_output("t1_addr", 32'(mem_addr), 32'h001234);
    @(posedge clk);
    #1;
    check_output("t1_rom_dato", 32'(rom_dato), 32'hA5);
    check_output("t1_oe_off", 32'(mem_oe), 32'd0);
    wait_idle(100);
    force_en = 1'b0;

    $display("[TB] directed RAM write");
    apply_stimulus(1'b0, 20'h0, 1'b1, 15'h0010, 1'b1, 8'h3C, 1);
    wait_idle(100);

    $display("[TB] simultaneous ROM read and RAM write");
    start = acc_count;
    apply_stimulus(1'b1, 20'h00456, 1'b1, 15'h0020, 1'b1, 8'hC3, 1);
    seen = 1'b0;
    n = 0;
    while (!(seen && !busy) && n < 60) begin
      @(posedge clk); #1;
      if (busy) seen = 1'b1;
      n++;
    end
    @(negedge clk); #1;
    check_output("both_busy_span", 32'(acc_count - start), 32'd2);
    wait_idle(100);

    $display("[TB] held strobe");
    start = acc_count;
    @(negedge clk);
    rom.ce = 1'b1; rom.oe = 1'b1; rom.addr = 20'h0ABCD;
    push_exp(1'b0, 1'b0, 22'h00ABCD, pattern(22'h00ABCD));
    repeat (20) @(posedge clk);
    @(negedge clk);
    rom = '0;
    wait_idle(100);
    check_output("hold_one_read", 32'(acc_count - start), 32'd1);
    start = acc_count;
    @(negedge clk);
    rom.ce = 1'b1; rom.oe = 1'b1; rom.addr = 20'h00F00;
    push_exp(1'b0, 1'b0, 22'h000F00, pattern(22'h000F00));
    repeat (8) @(posedge clk);
    @(negedge clk);
    rom.addr = 20'h00F80;
    push_exp(1'b0, 1'b0, 22'h000F80, pattern(22'h000F80));
    repeat (12) @(posedge clk);
    @(negedge clk);
    rom = '0;
    wait_idle(100);
    check_output("hold_addr_change", 32'(acc_count - start), 32'd2);

    $display("[TB] three triggers during a write");
    start = acc_count;
    @(negedge clk);
    ram.ce = 1'b1; ram.we = 1'b1; ram.addr = 20'h00040; ram.dati = 8'h77;
    push_exp(1'b1, 1'b1, RBASE + 22'h40, 8'h77);
    @(posedge clk);
    @(negedge clk);
    ram = '0;
    rom.ce = 1'b1; rom.oe = 1'b1; rom.addr = 20'h00010;
    @(posedge clk);
    @(negedge clk);
    rom.addr = 20'h00020;
    @(posedge clk);
    @(negedge clk);
    rom.addr = 20'h00030;
    push_exp(1'b0, 1'b0, 22'h000030, pattern(22'h000030));
    @(posedge clk);
    @(negedge clk);
    rom = '0;
    wait_idle(100);
    check_output("newest_wins_count", 32'(acc_count - start), 32'd2);

    $display("[TB] reset during write");
    apply_stimulus(1'b0, 20'h0, 1'b1, 15'h0055, 1'b0, 8'h00, 1);
    wait_idle(100);
    @(negedge clk);
    ram.ce = 1'b1; ram.we = 1'b1; ram.addr = 20'h00123; ram.dati = 8'h99;
    n = 0;
    while (!mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("rst_reach_wr", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rstmid_we", 32'(mem_we), 32'd0);
    check_output("rstmid_ce", 32'(mem_ce), 32'd0);
    check_output("rstmid_busy", 32'(busy), 32'd0);
    check_output("rstmid_rom_dato", 32'(rom_dato), 32'd0);
    check_output("rstmid_ram_dato", 32'(ram_dato), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_rom = 8'h00;
    model_ram = 8'h00;
    push_exp(1'b1, 1'b1, RBASE + 22'h123, 8'h99);
    @(posedge clk);
    @(negedge clk);
    ram = '0;
    wait_idle(100);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: apply_stimulus(1'b1, 20'($urandom), 1'b0, 15'h0, 1'b0, 8'h0, $urandom_range(1, 6));
        1: apply_stimulus(1'b0, 20'h0, 1'b1, 15'($urandom), 1'b0, 8'h0, $urandom_range(1, 6));
        2: apply_stimulus(1'b0, 20'h0, 1'b1, 15'($urandom), 1'b1, 8'($urandom), $urandom_range(1, 6));
        default: apply_stimulus(1'b1, 20'($urandom), 1'b1, 15'($urandom), 1'($urandom),
                                8'($urandom), $urandom_range(1, 6));
      endcase
      wait_idle(200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
